// File: rtl/csr_file_pkg.sv
// Shared CSR definitions for the LoongArch pipeline: CSR numbers, writable-field
// masks, exception codes and the masked-write helper.
package csr_file_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Bits of each CSR that software may change; everything else holds its value.
  localparam logic [31:0] CSR_CRMD_WMASK   = 32'h0000_01ff;
  localparam logic [31:0] CSR_PRMD_WMASK   = 32'h0000_0007;
  localparam logic [31:0] CSR_ECFG_WMASK   = 32'h0000_1bff;
  localparam logic [31:0] CSR_EENTRY_WMASK = 32'hffff_ffc0;

  localparam logic [5:0] CSR_ECODE_ADE     = 6'h08;
  localparam logic [5:0] CSR_ECODE_ALE     = 6'h09;
  localparam logic [8:0] CSR_ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] CSR_ESUBCODE_ADEM = 9'h001;

  function automatic logic [31:0] mask_write(input logic [31:0] old_val,
                                             input logic [31:0] wvalue,
                                             input logic [31:0] wmask);
    return (old_val & ~wmask) | (wvalue & wmask);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: TCFG, TVAL and the TI interrupt flag.
module csr_timer
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tcfg_we,
  input  logic [31:0] tcfg_wmask,
  input  logic [31:0] tcfg_wvalue,
  input  logic        ticlr,
  output logic [31:0] tcfg,
  output logic [31:0] tval,
  output logic        ti
);

  logic [31:0] tcfg_q, tcfg_d;
  logic [31:0] tval_q, tval_d;
  logic        ti_q, ti_d;

  always_comb begin
    tcfg_d = tcfg_q;
    tval_d = tval_q;
    ti_d   = ti_q;
    if (ticlr) ti_d = 1'b0;
    if (tcfg_we) begin
      tcfg_d = mask_write(tcfg_q, tcfg_wvalue, tcfg_wmask);
      tval_d = {tcfg_d[31:2], 2'b00};
    end else if (tcfg_q[0] && (tval_q != 32'hffff_ffff)) begin
      // Expiry sets TI (overriding a same-cycle clear) and reloads or parks.
      if (tval_q == 32'd0) begin
        ti_d   = 1'b1;
        tval_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'hffff_ffff;
      end else begin
        tval_d = tval_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg_q <= 32'd0;
      tval_q <= 32'd0;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      tval_q <= tval_d;
      ti_q   <= ti_d;
    end
  end

  assign tcfg = tcfg_q;
  assign tval = tval_q;
  assign ti   = ti_q;

endmodule

// File: rtl/csr_file.sv
// Control/status register file: CSR read/write, exception entry/return state,
// interrupt status and the stable timer.
module csr_file
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        ex_to_csr,
  input  logic        ertn_flush,
  input  logic [5:0]  ecode,
  input  logic [8:0]  esubcode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic [31:0] csr_rvalue,
  input  logic [7:0]  hw_int_in,
  input  logic        ipi_int_in,
  output logic [31:0] ex_entry,
  output logic [31:0] era_out,
  output logic        has_int
);

  logic [31:0]       crmd_q, crmd_d;
  logic [31:0]       prmd_q, prmd_d;
  logic [31:0]       ecfg_q, ecfg_d;
  logic [31:0]       era_q, era_d;
  logic [31:0]       badv_q, badv_d;
  logic [31:0]       eentry_q, eentry_d;
  logic [31:0]       tid_q, tid_d;
  logic [3:0][31:0]  save_q, save_d;
  logic [1:0]        is_sw_q, is_sw_d;
  logic [7:0]        hw_int_q, hw_int_d;
  logic              ipi_q, ipi_d;
  logic [5:0]        ecode_q, ecode_d;
  logic [8:0]        esubcode_q, esubcode_d;

  logic        wen;
  logic        tcfg_we;
  logic        ticlr;
  logic [31:0] tcfg;
  logic [31:0] tval;
  logic        ti;
  logic [31:0] estat;

  // Exception and ertn both take priority over a software write.
  assign wen     = csr_we & wb_valid & ~ex_to_csr & ~ertn_flush;
  assign tcfg_we = wen & (csr_num == CSR_TCFG);
  assign ticlr   = wen & (csr_num == CSR_TICLR) & csr_wmask[0] & csr_wvalue[0];

  csr_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .tcfg_we     (tcfg_we),
    .tcfg_wmask  (csr_wmask),
    .tcfg_wvalue (csr_wvalue),
    .ticlr       (ticlr),
    .tcfg        (tcfg),
    .tval        (tval),
    .ti          (ti)
  );

  assign estat = {1'b0, esubcode_q, ecode_q, 3'b000, ipi_q, ti, 1'b0, hw_int_q, is_sw_q};

  always_comb begin
    crmd_d     = crmd_q;
    prmd_d     = prmd_q;
    ecfg_d     = ecfg_q;
    era_d      = era_q;
    badv_d     = badv_q;
    eentry_d   = eentry_q;
    tid_d      = tid_q;
    save_d     = save_q;
    is_sw_d    = is_sw_q;
    ecode_d    = ecode_q;
    esubcode_d = esubcode_q;
    hw_int_d   = hw_int_in;
    ipi_d      = ipi_int_in;
    if (ex_to_csr) begin
      prmd_d[2:0] = crmd_q[2:0];
      crmd_d[2:0] = 3'b000;
      era_d       = wb_pc;
      ecode_d     = ecode;
      esubcode_d  = esubcode;
      if (ecode == CSR_ECODE_ADE && esubcode == CSR_ESUBCODE_ADEF) badv_d = wb_pc;
      else if (ecode == CSR_ECODE_ADE && esubcode == CSR_ESUBCODE_ADEM) badv_d = wb_vaddr;
      else if (ecode == CSR_ECODE_ALE) badv_d = wb_vaddr;
    end else if (ertn_flush) begin
      crmd_d[2:0] = prmd_q[2:0];
    end else if (wen) begin
      case (csr_num)
        CSR_CRMD:   crmd_d   = mask_write(crmd_q, csr_wvalue, csr_wmask & CSR_CRMD_WMASK);
        CSR_PRMD:   prmd_d   = mask_write(prmd_q, csr_wvalue, csr_wmask & CSR_PRMD_WMASK);
        CSR_ECFG:   ecfg_d   = mask_write(ecfg_q, csr_wvalue, csr_wmask & CSR_ECFG_WMASK);
        CSR_ESTAT:  is_sw_d  = (is_sw_q & ~csr_wmask[1:0]) | (csr_wvalue[1:0] & csr_wmask[1:0]);
        CSR_ERA:    era_d    = mask_write(era_q, csr_wvalue, csr_wmask);
        CSR_BADV:   badv_d   = mask_write(badv_q, csr_wvalue, csr_wmask);
        CSR_EENTRY: eentry_d = mask_write(eentry_q, csr_wvalue, csr_wmask & CSR_EENTRY_WMASK);
        CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
          save_d[csr_num[1:0]] = mask_write(save_q[csr_num[1:0]], csr_wvalue, csr_wmask);
        CSR_TID:    tid_d    = mask_write(tid_q, csr_wvalue, csr_wmask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_q     <= 32'h0000_0008;
      prmd_q     <= 32'd0;
      ecfg_q     <= 32'd0;
      era_q      <= 32'd0;
      badv_q     <= 32'd0;
      eentry_q   <= 32'd0;
      tid_q      <= 32'd0;
      save_q     <= '0;
      is_sw_q    <= 2'b00;
      hw_int_q   <= 8'd0;
      ipi_q      <= 1'b0;
      ecode_q    <= 6'd0;
      esubcode_q <= 9'd0;
    end else begin
      crmd_q     <= crmd_d;
      prmd_q     <= prmd_d;
      ecfg_q     <= ecfg_d;
      era_q      <= era_d;
      badv_q     <= badv_d;
      eentry_q   <= eentry_d;
      tid_q      <= tid_d;
      save_q     <= save_d;
      is_sw_q    <= is_sw_d;
      hw_int_q   <= hw_int_d;
      ipi_q      <= ipi_d;
      ecode_q    <= ecode_d;
      esubcode_q <= esubcode_d;
    end
  end

  always_comb begin
    csr_rvalue = 32'd0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = crmd_q;
      CSR_PRMD:   csr_rvalue = prmd_q;
      CSR_ECFG:   csr_rvalue = ecfg_q;
      CSR_ESTAT:  csr_rvalue = estat;
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = eentry_q;
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
        csr_rvalue = save_q[csr_num[1:0]];
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg;
      CSR_TVAL:   csr_rvalue = tval;
      default:    csr_rvalue = 32'd0;
    endcase
  end

  assign has_int  = crmd_q[2] & (|(estat[12:0] & ecfg_q[12:0]));
  assign ex_entry = eentry_q;
  assign era_out  = era_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file with hand-computed expectations.
module tb_csr_file;
  import csr_file_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        ex_to_csr;
  logic        ertn_flush;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic        has_int;

  int compared = 0;
  int mismatched = 0;

  csr_file dut (
    .clk        (clk),
    .reset      (reset),
    .wb_valid   (wb_valid),
    .ex_to_csr  (ex_to_csr),
    .ertn_flush (ertn_flush),
    .ecode      (ecode),
    .esubcode   (esubcode),
    .wb_pc      (wb_pc),
    .wb_vaddr   (wb_vaddr),
    .csr_we     (csr_we),
    .csr_num    (csr_num),
    .csr_wmask  (csr_wmask),
    .csr_wvalue (csr_wvalue),
    .csr_rvalue (csr_rvalue),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .ex_entry   (ex_entry),
    .era_out    (era_out),
    .has_int    (has_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkCsr(input string tag, input logic [13:0] num, input logic [31:0] expected);
    csr_num = num;
    #1;
    checkOutput(tag, csr_rvalue, expected);
  endtask

  task automatic applyStimulus(input logic [13:0] num, input logic [31:0] wmask,
                               input logic [31:0] wvalue, input logic valid);
    csr_we     = 1'b1;
    csr_num    = num;
    csr_wmask  = wmask;
    csr_wvalue = wvalue;
    wb_valid   = valid;
    tick();
    csr_we   = 1'b0;
    wb_valid = 1'b0;
  endtask

  task automatic raiseException(input logic [5:0] ec, input logic [8:0] esc,
                                input logic [31:0] pc, input logic [31:0] vaddr);
    ex_to_csr = 1'b1;
    ecode     = ec;
    esubcode  = esc;
    wb_pc     = pc;
    wb_vaddr  = vaddr;
    tick();
    ex_to_csr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wb_valid = 1'b0; ex_to_csr = 1'b0; ertn_flush = 1'b0;
    ecode = '0; esubcode = '0; wb_pc = '0; wb_vaddr = '0;
    csr_we = 1'b0; csr_num = '0; csr_wmask = '0; csr_wvalue = '0;
    hw_int_in = '0; ipi_int_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkCsr("reset_crmd", CSR_CRMD, 32'h0000_0008);
    checkCsr("reset_estat", CSR_ESTAT, 32'h0);
    checkCsr("reset_tval", CSR_TVAL, 32'h0);
    checkOutput("reset_has_int", {31'b0, has_int}, 32'h0);
    checkOutput("reset_ex_entry", ex_entry, 32'h0);
    checkOutput("reset_era_out", era_out, 32'h0);

    // Masked writes, invalid-qualified writes and field masks
    applyStimulus(CSR_SAVE0, 32'hffff_ffff, 32'haaaa_aaaa, 1'b1);
    applyStimulus(CSR_SAVE0, 32'h0000_ffff, 32'h1234_5678, 1'b1);
    checkCsr("save0_masked", CSR_SAVE0, 32'haaaa_5678);
    applyStimulus(CSR_SAVE0, 32'hffff_ffff, 32'h1111_1111, 1'b0);
    checkCsr("save0_no_valid", CSR_SAVE0, 32'haaaa_5678);
    csr_we = 1'b1; wb_valid = 1'b1; csr_num = CSR_SAVE0;
    csr_wmask = 32'hffff_ffff; csr_wvalue = 32'h0;
    #1;
    checkOutput("save0_read_old", csr_rvalue, 32'haaaa_5678);
    tick();
    csr_we = 1'b0; wb_valid = 1'b0;
    checkCsr("save0_after", CSR_SAVE0, 32'h0);
    applyStimulus(CSR_EENTRY, 32'hffff_ffff, 32'hffff_ffff, 1'b1);
    checkOutput("eentry_out", ex_entry, 32'hffff_ffc0);
    applyStimulus(CSR_ECFG, 32'hffff_ffff, 32'hffff_ffff, 1'b1);
    checkCsr("ecfg_bit10", CSR_ECFG, 32'h0000_1bff);
    checkCsr("ticlr_reads0", CSR_TICLR, 32'h0);

    // Exception entry and ertn
    applyStimulus(CSR_CRMD, 32'hffff_ffff, 32'h0000_0007, 1'b1);
    checkCsr("crmd_setup", CSR_CRMD, 32'h0000_0007);
    raiseException(CSR_ECODE_ADE, CSR_ESUBCODE_ADEF, 32'h1c00_0100, 32'hdead_0000);
    checkCsr("adef_prmd", CSR_PRMD, 32'h0000_0007);
    checkCsr("adef_crmd", CSR_CRMD, 32'h0);
    checkOutput("adef_era_out", era_out, 32'h1c00_0100);
    checkCsr("adef_badv", CSR_BADV, 32'h1c00_0100);
    checkCsr("adef_estat", CSR_ESTAT, 32'h0008_0000);
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    checkCsr("ertn_crmd", CSR_CRMD, 32'h0000_0007);
    raiseException(CSR_ECODE_ADE, CSR_ESUBCODE_ADEM, 32'h1c00_0200, 32'h0000_1234);
    checkCsr("adem_badv", CSR_BADV, 32'h0000_1234);
    checkCsr("adem_estat", CSR_ESTAT, 32'h0048_0000);

    // ALE with a simultaneous SAVE1 write that must be dropped
    applyStimulus(CSR_SAVE1, 32'hffff_ffff, 32'h0000_0055, 1'b1);
    csr_we = 1'b1; wb_valid = 1'b1; csr_num = CSR_SAVE1;
    csr_wmask = 32'hffff_ffff; csr_wvalue = 32'hffff_ffff;
    raiseException(CSR_ECODE_ALE, 9'h0, 32'h1c00_0300, 32'h0000_0003);
    csr_we = 1'b0; wb_valid = 1'b0;
    checkCsr("ale_badv", CSR_BADV, 32'h0000_0003);
    checkCsr("ale_save1", CSR_SAVE1, 32'h0000_0055);
    checkCsr("ale_prmd", CSR_PRMD, 32'h0);
    checkOutput("ale_era_out", era_out, 32'h1c00_0300);

    // One-shot timer
    applyStimulus(CSR_ECFG, 32'hffff_ffff, 32'h0000_0800, 1'b1);
    applyStimulus(CSR_CRMD, 32'h0000_0004, 32'h0000_0004, 1'b1);
    checkOutput("timer_no_int", {31'b0, has_int}, 32'h0);
    applyStimulus(CSR_TCFG, 32'hffff_ffff, 32'h0000_0009, 1'b1);
    checkCsr("oneshot_load", CSR_TVAL, 32'h0000_0008);
    repeat (8) tick();
    checkCsr("oneshot_zero", CSR_TVAL, 32'h0);
    checkCsr("oneshot_ti_pre", CSR_ESTAT, 32'h0009_0000);
    tick();
    checkCsr("oneshot_ti", CSR_ESTAT, 32'h0009_0800);
    checkCsr("oneshot_park", CSR_TVAL, 32'hffff_ffff);
    checkOutput("oneshot_has_int", {31'b0, has_int}, 32'h1);
    tick();
    checkCsr("oneshot_hold", CSR_TVAL, 32'hffff_ffff);
    applyStimulus(CSR_TICLR, 32'h0000_0001, 32'h0000_0001, 1'b1);
    checkCsr("ticlr_estat", CSR_ESTAT, 32'h0009_0000);
    checkOutput("ticlr_has_int", {31'b0, has_int}, 32'h0);

    // Periodic timer and clear colliding with expiry
    applyStimulus(CSR_TCFG, 32'hffff_ffff, 32'h0000_0007, 1'b1);
    checkCsr("periodic_load", CSR_TVAL, 32'h0000_0004);
    repeat (4) tick();
    checkCsr("periodic_zero", CSR_TVAL, 32'h0);
    applyStimulus(CSR_TICLR, 32'h0000_0001, 32'h0000_0001, 1'b1);
    checkCsr("periodic_ti_wins", CSR_ESTAT, 32'h0009_0800);
    checkCsr("periodic_reload", CSR_TVAL, 32'h0000_0004);
    applyStimulus(CSR_TICLR, 32'h0000_0001, 32'h0000_0001, 1'b1);
    checkCsr("periodic_cleared", CSR_ESTAT, 32'h0009_0000);
    checkCsr("periodic_count", CSR_TVAL, 32'h0000_0003);
    applyStimulus(CSR_TCFG, 32'hffff_ffff, 32'h0, 1'b1);
    tick();
    checkCsr("timer_stopped", CSR_TVAL, 32'h0);

    // Hardware interrupt latency
    applyStimulus(CSR_ECFG, 32'hffff_ffff, 32'h0000_0004, 1'b1);
    hw_int_in = 8'h01;
    #1;
    checkOutput("hwint_same_cycle", {31'b0, has_int}, 32'h0);
    tick();
    checkOutput("hwint_next_cycle", {31'b0, has_int}, 32'h1);
    checkCsr("hwint_estat", CSR_ESTAT, 32'h0009_0004);
    hw_int_in = 8'h00;
    tick();
    checkOutput("hwint_drop", {31'b0, has_int}, 32'h0);

    // Reset during an active count
    applyStimulus(CSR_TCFG, 32'hffff_ffff, 32'h0000_0041, 1'b1);
    repeat (3) tick();
    checkCsr("midcount_tval", CSR_TVAL, 32'h0000_003d);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkCsr("midreset_tcfg", CSR_TCFG, 32'h0);
    checkCsr("midreset_tval", CSR_TVAL, 32'h0);
    checkCsr("midreset_crmd", CSR_CRMD, 32'h0000_0008);
    repeat (2) tick();
    checkCsr("midreset_stopped", CSR_TVAL, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Control/status register file for the LoongArch pipeline. It is the receiving end of the write-back stage's exception and CSR-access interface: it serves CSR reads, commits masked CSR writes, and saves or restores privilege state on exception entry and `ertn`. It also runs the stable timer and produces the interrupt request that decode tags onto instructions. It sits beside `wb_stage` and drives `ex_entry`/`era` to the fetch stage.

## Interface
- No parameters. CSR numbers, field positions and ecodes come from the shared header.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  WB holds a valid instruction; qualifies `csr_we`
- ex_to_csr  in  1  exception commit (already valid-qualified)
- ertn_flush  in  1  `ertn` commit (already valid-qualified)
- ecode  in  6  exception code
- esubcode  in  9  exception subcode
- wb_pc  in  32  PC of the committing instruction
- wb_vaddr  in  32  faulting data address
- csr_we  in  1  CSR write request
- csr_num  in  14  CSR number, used for both read and write
- csr_wmask  in  32  per-bit write mask
- csr_wvalue  in  32  write data
- csr_rvalue  out  32  combinational read of `csr_num`; unimplemented numbers read 0
- hw_int_in  in  8  hardware interrupt lines, level
- ipi_int_in  in  1  inter-processor interrupt, level
- ex_entry  out  32  EENTRY
- era_out  out  32  ERA
- has_int  out  1  pending enabled interrupt

## Operation
- Registers, with reset values:
  - CRMD 0x0: PLV[1:0], IE[2], DA[3] (reset 1), PG[4], DATF[6:5], DATM[8:7]. Reset value 0x00000008.
  - PRMD 0x1: PPLV[1:0], PIE[2].
  - ECFG 0x4: LIE[9:0], LIE[12:11]. Bit 10 reads 0.
  - ESTAT 0x5: IS[1:0] software-writable; IS[9:2] = hw_int_in; IS[11] = TI; IS[12] = ipi_int_in; Ecode[21:16]; EsubCode[30:22].
  - ERA 0x6; BADV 0x7.
  - EENTRY 0xC: VA[31:6], bits [5:0] read 0.
  - SAVE0-3 0x30-0x33.
  - TID 0x40.
  - TCFG 0x41: En[0], Periodic[1], InitVal[31:2].
  - TVAL 0x42: read-only.
  - TICLR 0x44: reads 0.
  - All registers and fields not listed above reset to 0.
- Write rule: effective write enable `wen = csr_we & wb_valid & ~ex_to_csr`. Each writable field updates as `(old & ~wmask) | (wvalue & wmask)`. Read-only fields ignore writes.
- Exception entry (`ex_to_csr`):
  - PRMD.PPLV <= CRMD.PLV; PRMD.PIE <= CRMD.IE.
  - CRMD.PLV <= 0; CRMD.IE <= 0.
  - ERA <= wb_pc.
  - ESTAT.Ecode/EsubCode <= ecode/esubcode.
  - BADV update:
    - ecode ADE (0x8) with esubcode 0 (ADEF): BADV <= wb_pc.
    - ecode ADE (0x8) with esubcode 1 (ADEM): BADV <= wb_vaddr.
    - ecode ALE (0x9): BADV <= wb_vaddr.
- `ertn_flush`: CRMD.PLV <= PRMD.PPLV; CRMD.IE <= PRMD.PIE.
- Priority: `ex_to_csr` > `ertn_flush` > `wen`. Simultaneous `ex_to_csr` and `ertn_flush` is treated as an exception.
- Timer:
  - A TCFG write loads TVAL <= {new InitVal, 2'b00}.
  - Otherwise, if En=1 and TVAL != 0xFFFFFFFF, TVAL decrements by 1 each cycle.
  - When a counting cycle sees TVAL==0: TI <= 1. TVAL then reloads {InitVal,00} if Periodic=1, else becomes 0xFFFFFFFF and holds.
- TICLR: a write with `wmask[0]&wvalue[0]` clears TI. A TI set in the same cycle wins over the clear.
- `has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0])`, computed combinationally from registered state. IS[9:2], IS[12] and IS[11] are registered every cycle.

## Timing
- All CSR updates land on the clk edge. `csr_rvalue` reflects pre-edge state, so a read in the same cycle as a write to the same CSR returns the old value.
- `ex_entry` and `era_out` are direct register outputs: the ERA written by an exception is visible on `era_out` the next cycle.
- Interrupt path: an interrupt line asserted in cycle N appears in ESTAT.IS in cycle N+1, and `has_int` rises in N+1 if enabled.
- Timer: the TCFG write takes effect at edge N. TVAL counts from edge N+1. TI is set at the edge after TVAL==0 is observed.
- Output values after reset: `has_int`=0, `ex_entry`=0, `era_out`=0. `csr_rvalue` is the read of reset state, e.g. CRMD reads 0x8.
- Reset asserted mid-count clears TCFG and TVAL; the timer stops.

## Structure
- The shared header `mycpu.h` gains:
  - CSR number defines: `CSR_CRMD` … `CSR_TICLR`.
  - Field bit ranges.
  - `CSR_ECODE_*` and `CSR_ESUBCODE_ADEF`/`ADEM`.
- Sub-module `csr_timer` holds TCFG, TVAL and TI, with ports for write strobe, write data, clear strobe and TI output.
- The remaining CSRs, the read mux and `has_int` live in `csr_file`.

## Test plan
- **Reset:** pulse reset, read CRMD, ESTAT, TVAL → 0x8, 0, 0; `has_int`=0.
- **Masked write:** write SAVE0 wmask=0x0000FFFF, wvalue=0x12345678 over 0xAAAAAAAA → reads 0xAAAA5678. Same write with wb_valid=0 → no change.
- **Exception then ertn:**
  - Setup: CRMD=0x7 (PLV=3, IE=1).
  - Exception: ex_to_csr with ecode 0x8, esubcode 0, wb_pc=0x1C000100.
  - Required after exception: PRMD=0x7, CRMD.PLV/IE=0, ERA=0x1C000100, BADV=0x1C000100, ESTAT[21:16]=0x8.
  - Then ertn_flush: CRMD.PLV/IE restored to 3/1.
- **ALE with simultaneous write:** ex_to_csr ecode 0x9, wb_vaddr=0x00000003, csr_we=1 to SAVE1 in the same cycle → BADV=0x3; SAVE1 unchanged.
- **One-shot timer:**
  - Setup: TCFG write 0x9 (InitVal=2, En=1, one-shot); TVAL=8 next cycle.
  - TI=1 nine cycles after the write; TVAL then holds 0xFFFFFFFF.
  - With ECFG.LIE[11]=1 and CRMD.IE=1 → `has_int`=1.
  - TICLR write of 1 → TI=0 and `has_int`=0 next cycle.
- **Periodic timer / simultaneous events:**
  - Periodic TCFG=0x7 (InitVal=1) → TVAL reloads 4 after reaching 0.
  - A TICLR write in the same cycle TI is set leaves TI=1.
  - hw_int_in[0] with LIE[2]=1 → `has_int` rises one cycle later.
